psum_collect: RTL and testbench

- Sink for the accumulated-sum stream from the psum ping-pong accumulator (`result_valid`/`result`). That stream has no backpressure, so this block must accept one sample every cycle.
- Per sample: rounding right-shift, optional ReLU, saturation to QWIDTH.
- Packs PACK quantized values into one output word and buffers words in a small FIFO.
- Presents words with word addresses to the output-buffer writer over a valid/ready interface.

---
 rtl/psum_collect.sv | 159 +++++++++++++++
 tb/tb_psum_collect.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_collect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// psum_collect : quantize the psum result stream, pack PACK lanes per word,
//                queue words with addresses for the output-buffer writer.
// Revision     : 1.0
// ---------------------------------------------------------------------------
module psum_collect #(
   parameter int DWIDTH  = 32,
   parameter int QWIDTH  = 8,
   parameter int PACK    = 4,
   parameter int AWIDTH  = 4,
   parameter int OADDR_W = 12
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [4:0]               cfg_shift,
   input  logic                     cfg_relu,
   input  logic                     frame_start,
   input  logic                     flush,
   input  logic                     result_valid,
   input  logic [DWIDTH-1:0]        result,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PACK*QWIDTH-1:0]   out_data,
   output logic [OADDR_W-1:0]       out_addr,
   output logic                     busy,
   output logic                     overflow
);

   localparam int CW    = (PACK > 1) ? $clog2(PACK) : 1;
   localparam int WW    = PACK * QWIDTH;
   localparam int DEPTH = 1 << AWIDTH;
   localparam logic signed [DWIDTH:0] QMAX = (DWIDTH+1)'((1 << (QWIDTH-1)) - 1);
   localparam logic signed [DWIDTH:0] QMIN = ~QMAX;
   localparam logic signed [DWIDTH:0] ONE  = (DWIDTH+1)'(1);

   logic signed [DWIDTH:0] ext, rnd_add, sum, shifted;
   logic [QWIDTH-1:0]      quant;

   logic                   s1_valid_q;
   logic [QWIDTH-1:0]      s1_data_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [WW-1:0]          word_q, word_d, filled;
   logic                   push_q, push_d;
   logic [WW-1:0]          push_word_q, push_word_d;
   logic                   pflush_q, pflush_d;

   logic [AWIDTH:0]        wr_q, rd_q;
   logic [OADDR_W-1:0]     addr_q;
   logic                   ovf_q;
   logic [WW-1:0]          mem [DEPTH];
   logic                   empty, full, pop, accept, drop;

   // One extra bit of headroom keeps the rounding add from wrapping.
   always_comb begin
      ext     = {result[DWIDTH-1], result};
      rnd_add = '0;
      if (cfg_shift != 5'd0) rnd_add = ONE << (cfg_shift - 5'd1);
      sum     = ext + rnd_add;
      shifted = sum >>> cfg_shift;
      if (cfg_relu && shifted[DWIDTH]) quant = '0;
      else if (shifted > QMAX)         quant = QMAX[QWIDTH-1:0];
      else if (shifted < QMIN)         quant = QMIN[QWIDTH-1:0];
      else                             quant = shifted[QWIDTH-1:0];
   end

   // A pending stage-1 sample is always packed before a flush takes effect.
   always_comb begin
      cnt_d       = cnt_q;
      word_d      = word_q;
      push_d      = 1'b0;
      push_word_d = push_word_q;
      pflush_d    = pflush_q;
      filled      = word_q;
      filled[cnt_q*QWIDTH +: QWIDTH] = s1_data_q;
      if (s1_valid_q) begin
         if (cnt_q == CW'(PACK-1)) begin
            push_d      = 1'b1;
            push_word_d = filled;
            word_d      = '0;
            cnt_d       = '0;
         end else begin
            word_d = filled;
            cnt_d  = cnt_q + CW'(1);
         end
         if (flush) pflush_d = 1'b1;
      end else if (flush || pflush_q) begin
         pflush_d = 1'b0;
         if (cnt_q != '0) begin
            push_d      = 1'b1;
            push_word_d = word_q;
            word_d      = '0;
            cnt_d       = '0;
         end
      end
      if (frame_start) begin
         cnt_d    = '0;
         word_d   = '0;
         push_d   = 1'b0;
         pflush_d = 1'b0;
      end
   end

   assign empty  = (wr_q == rd_q);
   assign full   = (wr_q[AWIDTH] != rd_q[AWIDTH]) &&
                   (wr_q[AWIDTH-1:0] == rd_q[AWIDTH-1:0]);
   assign pop    = ~empty & out_ready;
   assign accept = push_q & (~full | pop);
   assign drop   = push_q & full & ~pop;

   always_ff @(posedge clk) begin
      if (accept) mem[wr_q[AWIDTH-1:0]] <= push_word_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         cnt_q       <= '0;
         word_q      <= '0;
         push_q      <= 1'b0;
         push_word_q <= '0;
         pflush_q    <= 1'b0;
         wr_q        <= '0;
         rd_q        <= '0;
         addr_q      <= '0;
         ovf_q       <= 1'b0;
      end else begin
         s1_valid_q  <= result_valid & ~frame_start;
         if (result_valid) s1_data_q <= quant;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         push_q      <= push_d;
         push_word_q <= push_word_d;
         pflush_q    <= pflush_d;
         if (frame_start) begin
            wr_q   <= '0;
            rd_q   <= '0;
            addr_q <= '0;
            ovf_q  <= 1'b0;
         end else begin
            if (accept) wr_q <= wr_q + (AWIDTH+1)'(1);
            if (pop) begin
               rd_q   <= rd_q + (AWIDTH+1)'(1);
               addr_q <= addr_q + OADDR_W'(1);
            end
            if (drop) ovf_q <= 1'b1;
         end
      end
   end

   assign out_valid = ~empty;
   assign out_data  = empty ? '0 : mem[rd_q[AWIDTH-1:0]];
   assign out_addr  = addr_q;
   assign overflow  = ovf_q;
   assign busy      = s1_valid_q | (cnt_q != '0) | pflush_q | push_q | ~empty;

endmodule
`default_nettype wire

// File: tb/tb_psum_collect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_psum_collect : directed scoreboard bench for psum_collect.
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_psum_collect;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [4:0]  cfg_shift = 5'd0;
   logic        cfg_relu = 1'b0;
   logic        frame_start = 1'b0;
   logic        flush = 1'b0;
   logic        result_valid = 1'b0;
   logic [31:0] result = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [11:0] out_addr;
   logic        busy;
   logic        overflow;

   typedef struct packed {
      logic [11:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   next_addr = 0;

   psum_collect dut (
      .clk(clk), .rstn(rstn), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
      .frame_start(frame_start), .flush(flush), .result_valid(result_valid),
      .result(result), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_addr(out_addr), .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] qmodel(input int v, input int sh, input bit relu);
      longint x;
      x = longint'(v);
      if (sh > 0) x = x + (longint'(1) <<< (sh - 1));
      x = x >>> sh;
      if (relu && x < 0) x = 0;
      if (x > 127) x = 127;
      if (x < -128) x = -128;
      return x[7:0];
   endfunction

   task automatic expect_word(input logic [31:0] d);
      exp_t e;
      e.addr = 12'(next_addr);
      e.data = d;
      sb.push_back(e);
      next_addr++;
   endtask

   task automatic send(input int v);
      result = v;
      result_valid = 1'b1;
      @(posedge clk); #1;
      result_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic frame();
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      sb.delete();
      next_addr = 0;
      chk("frame_out_valid", out_valid, 1'b0);
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while ((sb.size() != 0 || busy) && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      chk(tag, (k < 400), 1'b1);
   endtask

   // Random word using the bench quantizer model; optionally scoreboarded.
   task automatic rand_word(input bit keep);
      logic [31:0] w;
      int v;
      w = '0;
      for (int l = 0; l < 4; l++) begin
         v = int'($urandom_range(0, 40000)) - 20000;
         w[l*8 +: 8] = qmodel(v, int'(cfg_shift), cfg_relu);
         send(v);
      end
      if (keep) expect_word(w);
   endtask

   always @(negedge clk) begin
      if (rstn && out_valid && out_ready) begin
         chk("sb_nonempty", sb.size() != 0, 1'b1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_addr", out_addr, e.addr);
         end
      end
   end

   initial begin
      idle(3);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_out_addr", out_addr, 12'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      rstn = 1'b1;
      idle(2);

      // Rounding shift and saturation.
      out_ready = 1'b1;
      cfg_shift = 5'd4;
      cfg_relu  = 1'b0;
      expect_word(32'h7FF01110);
      send(32'h100); send(32'h108); send(-32'sh108); send(32'h7FFFFFFF);
      drain("drain_shift");

      // ReLU with no shift.
      cfg_shift = 5'd0;
      cfg_relu  = 1'b1;
      expect_word(32'h7F000300);
      send(-5); send(3); send(-1000); send(200);
      drain("drain_relu");

      // Flush with a sample still pending in stage 1.
      cfg_relu = 1'b0;
      frame();
      expect_word(32'h01010101);
      expect_word(32'h00000101);
      repeat (6) send(1);
      pulse_flush();
      drain("drain_flush");
      chk("flush_busy", busy, 1'b0);

      // Flush with nothing pending, then flush as a no-op.
      expect_word(32'h00000302);
      send(2); send(3);
      idle(2);
      pulse_flush();
      drain("drain_flush2");
      pulse_flush();
      idle(4);
      chk("noop_flush_valid", out_valid, 1'b0);
      chk("noop_flush_busy", busy, 1'b0);

      // Fill the FIFO, drop the 17th word.
      cfg_shift = 5'd4;
      frame();
      out_ready = 1'b0;
      for (int w = 0; w < 16; w++) rand_word(1'b1);
      idle(4);
      chk("full_no_ovf", overflow, 1'b0);
      rand_word(1'b0);
      idle(4);
      chk("ovf_set", overflow, 1'b1);
      chk("ovf_out_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      drain("drain_ovf");
      chk("ovf_sticky", overflow, 1'b1);
      frame();
      chk("ovf_cleared", overflow, 1'b0);

      // Push on a full FIFO together with a pop is accepted.
      out_ready = 1'b0;
      for (int w = 0; w < 16; w++) rand_word(1'b1);
      idle(4);
      rand_word(1'b1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain("drain_simul");
      chk("simul_no_ovf", overflow, 1'b0);

      // Mid-word frame_start discards partial lanes and the coincident sample.
      cfg_shift = 5'd0;
      send(50); send(60);
      result = 70;
      result_valid = 1'b1;
      frame_start = 1'b1;
      @(posedge clk); #1;
      result_valid = 1'b0;
      frame_start = 1'b0;
      sb.delete();
      next_addr = 0;
      expect_word(32'h04030201);
      send(1); send(2); send(3); send(4);
      drain("drain_frame");
      idle(5);
      chk("frame_quiet", out_valid, 1'b0);

      // Asynchronous reset mid-stream.
      out_ready = 1'b0;
      repeat (6) send(9);
      idle(3);
      chk("pre_rst_valid", out_valid, 1'b1);
      rstn = 1'b0;
      #2;
      sb.delete();
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_out_data", out_data, 32'h0);
      chk("arst_out_addr", out_addr, 12'h0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_overflow", overflow, 1'b0);
      @(posedge clk); #1;
      rstn = 1'b1;
      idle(3);
      chk("post_rst_busy", busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
